// File: rtl/fft_frame_sched_if.sv
// FIFO read port and FFT output stream of the frame scheduler, bundled for port connection.
// master = scheduler side, slave = FIFO/FFT environment side.
interface fft_frame_sched_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_rd_en;
  logic                  fifo_rd_vld;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_first;
  logic                  m_last;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_vld,
    input  fifo_rd_data,
    output m_valid,
    output m_data,
    output m_first,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_vld,
    output fifo_rd_data,
    input  m_valid,
    input  m_data,
    input  m_first,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fft_frame_sched.sv
// Pops FIFO samples into FRAME_LEN-sample frames for the FFT, with GAP_CYCLES idle cycles between frames.
// Latency 1 clk from pop to m_valid; single output slot refills on the accept cycle, so 1 sample/clk.
module fft_frame_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int GAP_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   flush,
  fft_frame_sched_if.master      io,
  output logic                   frame_done,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            stall_cnt,
  output logic                   busy
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [7:0]  GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           pop_idx_q, pop_idx_d;
  logic [7:0]            gap_q, gap_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_first_q, m_first_d;
  logic                  m_last_q, m_last_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  logic slot_free;
  logic pop;
  logic last_acc;

  always_comb begin
    slot_free = !m_valid_q || io.m_ready;
    pop       = (state_q == ST_STREAM) && io.fifo_rd_vld && slot_free && !flush;
    last_acc  = (state_q == ST_DRAIN) && m_valid_q && io.m_ready && !flush;

    state_d     = state_q;
    pop_idx_d   = pop_idx_q;
    gap_d       = gap_q;
    m_valid_d   = m_valid_q && !io.m_ready;
    m_data_d    = m_data_q;
    m_first_d   = m_first_q;
    m_last_d    = m_last_q;
    frame_cnt_d = frame_cnt_q + {15'd0, last_acc};
    stall_cnt_d = stall_cnt_q;

    if (state_q == ST_STREAM && slot_free && !io.fifo_rd_vld && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    if (pop) begin
      m_valid_d = 1'b1;
      m_data_d  = io.fifo_rd_data;
      m_first_d = (pop_idx_q == 16'd0);
      m_last_d  = (pop_idx_q == LAST_IDX);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_STREAM;
          pop_idx_d = 16'd0;
        end
      end
      ST_STREAM: begin
        if (pop) begin
          if (pop_idx_q == LAST_IDX) begin
            state_d   = ST_DRAIN;
            pop_idx_d = 16'd0;
          end else begin
            pop_idx_d = pop_idx_q + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (last_acc) begin
          gap_d     = 8'd0;
          pop_idx_d = 16'd0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
          end else begin
            state_d = enable ? ST_STREAM : ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d     = 8'd0;
          pop_idx_d = 16'd0;
          state_d   = enable ? ST_STREAM : ST_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush drops the held beat and the partial frame but leaves the counters alone.
    if (flush) begin
      state_d   = ST_IDLE;
      pop_idx_d = 16'd0;
      gap_d     = 8'd0;
      m_valid_d = 1'b0;
      m_first_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pop_idx_q   <= 16'd0;
      gap_q       <= 8'd0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_first_q   <= 1'b0;
      m_last_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pop_idx_q   <= pop_idx_d;
      gap_q       <= gap_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_first_q   <= m_first_d;
      m_last_q    <= m_last_d;
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign io.fifo_rd_en = pop;
  assign io.m_valid    = m_valid_q;
  assign io.m_data     = m_data_q;
  assign io.m_first    = m_first_q;
  assign io.m_last     = m_last_q;
  assign frame_done    = last_acc;
  assign frame_cnt     = frame_cnt_q;
  assign stall_cnt     = stall_cnt_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
